// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps fetch addresses, resolves taken branches through
// the external target table, and reports run/done/fault status with saturating counters.
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            branch_en,
  input  logic            branch_taken,
  input  logic [8:0]      branch_key,
  output logic [8:0]      lut_address,
  input  logic [15:0]     lut_val,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            fault,
  output logic [PC_W-1:0] fault_pc,
  output logic [15:0]     cycle_count,
  output logic [15:0]     branch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [PC_W-1:0] L_START = PC_W'(START_PC);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_faultPc;
  logic            r_running;
  logic            r_done;
  logic            r_fault;
  logic [15:0]     r_cycleCount;
  logic [15:0]     r_branchCount;

  logic            w_targetBad;
  logic [PC_W-1:0] w_target;

  // A zero entry means the key is unmapped; anything above the program space is unreachable.
  assign w_targetBad = (lut_val == 16'd0) || ((lut_val >> PC_W) != 16'd0);
  assign w_target    = lut_val[PC_W-1:0];

  assign lut_address  = branch_key;
  assign pc           = r_pc;
  assign running      = r_running;
  assign done         = r_done;
  assign fault        = r_fault;
  assign fault_pc     = r_faultPc;
  assign cycle_count  = r_cycleCount;
  assign branch_count = r_branchCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= L_START;
      r_faultPc     <= '0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_cycleCount  <= 16'd0;
      r_branchCount <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            r_state       <= S_RUN;
            r_pc          <= L_START;
            r_faultPc     <= '0;
            r_running     <= 1'b1;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_cycleCount  <= 16'd0;
            r_branchCount <= 16'd0;
          end
        end
        S_RUN: begin
          // Stalled cycles still count as time spent running.
          if (r_cycleCount != 16'hFFFF) r_cycleCount <= r_cycleCount + 16'd1;
          if (!stall) begin
            if (halt_req) begin
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else if (branch_en && branch_taken) begin
              if (w_targetBad) begin
                r_state   <= S_FAULT;
                r_running <= 1'b0;
                r_fault   <= 1'b1;
                r_faultPc <= r_pc;
              end else begin
                r_pc <= w_target;
                if (r_branchCount != 16'hFFFF) r_branchCount <= r_branchCount + 16'd1;
              end
            end else if (r_pc == '1) begin
              r_state   <= S_FAULT;
              r_running <= 1'b0;
              r_fault   <= 1'b1;
              r_faultPc <= r_pc;
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
          r_fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written corner
// sequences, randomized run against a behavioural model, plus a 4-bit runaway instance.
module tb_pc_sequencer;

  localparam int PC_W    = 10;
  localparam int PC_SPAN = 1 << PC_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, stall, haltReq, branchEn, branchTaken;
  logic [8:0]      branchKey, lutAddress;
  logic [15:0]     lutVal;
  logic [PC_W-1:0] pc, faultPc;
  logic            running, done, fault;
  logic [15:0]     cycleCount, branchCount;

  logic [15:0] lutTable [512];

  // The bench plays the role of the combinational target table.
  always_comb lutVal = lutTable[lutAddress];

  pc_sequencer #(.PC_W(PC_W), .START_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(haltReq),
    .branch_en(branchEn), .branch_taken(branchTaken), .branch_key(branchKey),
    .lut_address(lutAddress), .lut_val(lutVal), .pc(pc), .running(running),
    .done(done), .fault(fault), .fault_pc(faultPc), .cycle_count(cycleCount),
    .branch_count(branchCount)
  );

  logic        sReset, sStart;
  logic [3:0]  sPc, sFaultPc;
  logic        sRunning, sDone, sFault;
  logic [15:0] sCycle, sBranch;
  logic [8:0]  sLutAddr;

  pc_sequencer #(.PC_W(4), .START_PC(0)) dutSmall (
    .clk(clk), .reset(sReset), .start(sStart), .stall(1'b0), .halt_req(1'b0),
    .branch_en(1'b0), .branch_taken(1'b0), .branch_key(9'd0),
    .lut_address(sLutAddr), .lut_val(16'd0), .pc(sPc), .running(sRunning),
    .done(sDone), .fault(sFault), .fault_pc(sFaultPc), .cycle_count(sCycle),
    .branch_count(sBranch)
  );

  int passCount  = 0;
  int checkCount = 0;

  int mPc, mFaultPc, mCycle, mBranch;
  bit mRunning, mDone, mFault;

  typedef struct {
    bit         start, stall, halt, ben, btaken;
    logic [8:0] key;
    int         ePc;
    bit         eRun, eDone, eFault;
    int         eFaultPc, eCycle, eBranch;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(bit st, bit sl, bit h, bit be, bit bt, logic [8:0] k,
                                 int p, bit r, bit d, bit f, int fp, int c, int b);
    vec_t v;
    v.start = st; v.stall = sl; v.halt = h; v.ben = be; v.btaken = bt; v.key = k;
    v.ePc = p; v.eRun = r; v.eDone = d; v.eFault = f; v.eFaultPc = fp;
    v.eCycle = c; v.eBranch = b;
    vecs.push_back(v);
  endfunction

  // Reference behaviour, stated in terms of the architectural rules rather than states.
  function automatic void modelStep(bit iReset, bit iStart, bit iStall, bit iHalt,
                                    bit iBen, bit iBtaken, logic [8:0] iKey);
    int t;
    t = int'(lutTable[iKey]);
    if (iReset) begin
      mPc = 0; mFaultPc = 0; mCycle = 0; mBranch = 0;
      mRunning = 0; mDone = 0; mFault = 0;
    end else if (mRunning) begin
      mCycle = (mCycle < 65535) ? mCycle + 1 : 65535;
      if (!iStall) begin
        if (iHalt) begin
          mRunning = 0; mDone = 1;
        end else if (iBen && iBtaken) begin
          if (t == 0 || t >= PC_SPAN) begin
            mRunning = 0; mFault = 1; mFaultPc = mPc;
          end else begin
            mPc = t;
            mBranch = (mBranch < 65535) ? mBranch + 1 : 65535;
          end
        end else if (mPc == PC_SPAN - 1) begin
          mRunning = 0; mFault = 1; mFaultPc = mPc;
        end else begin
          mPc = mPc + 1;
        end
      end
    end else if (iStart) begin
      mPc = 0; mFaultPc = 0; mCycle = 0; mBranch = 0;
      mRunning = 1; mDone = 0; mFault = 0;
    end
  endfunction

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkOutput(input string tag, input int ePc, input bit eRun, input bit eDone,
                             input bit eFault, input int eFaultPc, input int eCycle, input int eBranch);
    checkField({tag, ".pc"}, 32'(pc), ePc);
    checkField({tag, ".running"}, 32'(running), 32'(eRun));
    checkField({tag, ".done"}, 32'(done), 32'(eDone));
    checkField({tag, ".fault"}, 32'(fault), 32'(eFault));
    checkField({tag, ".fault_pc"}, 32'(faultPc), eFaultPc);
    checkField({tag, ".cycle_count"}, 32'(cycleCount), eCycle);
    checkField({tag, ".branch_count"}, 32'(branchCount), eBranch);
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mPc, mRunning, mDone, mFault, mFaultPc, mCycle, mBranch);
  endtask

  task automatic applyStimulus(input bit iReset, input bit iStart, input bit iStall, input bit iHalt,
                               input bit iBen, input bit iBtaken, input logic [8:0] iKey);
    @(negedge clk);
    reset = iReset; start = iStart; stall = iStall; haltReq = iHalt;
    branchEn = iBen; branchTaken = iBtaken; branchKey = iKey;
    #1 checkField("lut_address", 32'(lutAddress), 32'(iKey));
    @(posedge clk);
    modelStep(iReset, iStart, iStall, iHalt, iBen, iBtaken, iKey);
    #1;
  endtask

  initial begin
    reset = 1; start = 0; stall = 0; haltReq = 0; branchEn = 0; branchTaken = 0; branchKey = '0;
    sReset = 1; sStart = 0;
    for (int i = 0; i < 512; i++) lutTable[i] = 16'd0;
    lutTable[9'h01D] = 16'd10;
    lutTable[9'h055] = 16'd0;
    lutTable[9'h0C0] = 16'd12;
    lutTable[9'h100] = 16'd1024;
    lutTable[9'h101] = 16'd1023;

    applyStimulus(1, 0, 0, 0, 0, 0, 9'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 9'd0);
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 0);

    addVec(1,0,0,0,0,9'h000,    0,1,0,0,   0, 0,0);
    addVec(0,0,0,0,0,9'h000,    1,1,0,0,   0, 1,0);
    addVec(0,0,0,0,0,9'h000,    2,1,0,0,   0, 2,0);
    addVec(0,0,0,0,0,9'h000,    3,1,0,0,   0, 3,0);
    addVec(0,0,0,0,0,9'h000,    4,1,0,0,   0, 4,0);
    addVec(0,0,0,0,0,9'h000,    5,1,0,0,   0, 5,0);
    addVec(0,0,1,0,0,9'h000,    5,0,1,0,   0, 6,0);
    addVec(1,0,0,0,0,9'h000,    0,1,0,0,   0, 0,0);
    addVec(0,0,0,0,0,9'h000,    1,1,0,0,   0, 1,0);
    addVec(0,0,0,0,0,9'h000,    2,1,0,0,   0, 2,0);
    addVec(0,0,0,0,0,9'h000,    3,1,0,0,   0, 3,0);
    addVec(0,0,0,1,1,9'h01D,   10,1,0,0,   0, 4,1);
    addVec(0,0,1,0,0,9'h000,   10,0,1,0,   0, 5,1);
    addVec(1,0,0,0,0,9'h000,    0,1,0,0,   0, 0,0);
    addVec(0,0,0,0,0,9'h000,    1,1,0,0,   0, 1,0);
    addVec(0,0,0,0,0,9'h000,    2,1,0,0,   0, 2,0);
    addVec(0,0,0,0,0,9'h000,    3,1,0,0,   0, 3,0);
    addVec(0,0,0,0,0,9'h000,    4,1,0,0,   0, 4,0);
    addVec(0,0,0,1,0,9'h01D,    5,1,0,0,   0, 5,0);
    addVec(0,1,0,0,0,9'h000,    5,1,0,0,   0, 6,0);
    addVec(0,1,0,0,0,9'h000,    5,1,0,0,   0, 7,0);
    addVec(0,1,0,0,0,9'h000,    5,1,0,0,   0, 8,0);
    addVec(0,0,0,0,0,9'h000,    6,1,0,0,   0, 9,0);
    addVec(0,0,0,0,0,9'h000,    7,1,0,0,   0,10,0);
    addVec(0,0,0,1,1,9'h055,    7,0,0,1,   7,11,0);
    addVec(0,0,0,0,0,9'h000,    7,0,0,1,   7,11,0);
    addVec(1,0,0,0,0,9'h000,    0,1,0,0,   0, 0,0);
    addVec(0,0,0,1,1,9'h0C0,   12,1,0,0,   0, 1,1);
    addVec(0,0,1,1,1,9'h01D,   12,0,1,0,   0, 2,1);
    addVec(0,0,0,1,1,9'h01D,   12,0,1,0,   0, 2,1);
    addVec(1,0,0,0,0,9'h000,    0,1,0,0,   0, 0,0);
    addVec(0,0,0,1,1,9'h100,    0,0,0,1,   0, 1,0);
    addVec(1,0,0,0,0,9'h000,    0,1,0,0,   0, 0,0);
    addVec(0,0,0,1,1,9'h101, 1023,1,0,0,   0, 1,1);
    addVec(0,0,0,0,0,9'h000, 1023,0,0,1,1023, 2,1);
    addVec(1,0,0,0,0,9'h000,    0,1,0,0,   0, 0,0);
    addVec(1,0,0,0,0,9'h000,    1,1,0,0,   0, 1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].ben,
                    vecs[i].btaken, vecs[i].key);
      checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eRun, vecs[i].eDone,
                  vecs[i].eFault, vecs[i].eFaultPc, vecs[i].eCycle, vecs[i].eBranch);
    end

    // A branch held through a multi-cycle stall resolves on the first free edge.
    applyStimulus(1, 0, 0, 0, 0, 0, 9'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 9'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 9'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 9'd0);
    checkOutput("preStall", 2, 1, 0, 0, 0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 1, 9'h0C0);
      checkOutput($sformatf("stallBr%0d", i), 2, 1, 0, 0, 0, 3 + i, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 9'h0C0);
    checkOutput("stallBrRelease", 12, 1, 0, 0, 0, 6, 1);

    applyStimulus(1, 1, 1, 0, 1, 1, 9'h0C0);
    checkOutput("resetMidStall", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 512; i++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) lutTable[i] = 16'd0;
      else if (r == 1) lutTable[i] = 16'(1024 + $urandom_range(0, 64000));
      else lutTable[i] = 16'($urandom_range(1, 1023));
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 9'd0);
    for (int i = 0; i < 600; i++) begin
      bit rr, st, sl, h, be, bt;
      rr = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 15) == 0);
      sl = st ? 1'b0 : ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 31) == 0);
      be = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 1) == 1);
      applyStimulus(rr, st, sl, h, be, bt, 9'($urandom_range(0, 511)));
      checkModel($sformatf("rand%0d", i));
    end

    // Runaway off the end of a 16-word program space.
    @(negedge clk); sReset = 1; sStart = 0;
    @(negedge clk); sReset = 0; sStart = 1;
    @(posedge clk); #1;
    checkField("small.startPc", 32'(sPc), 0);
    checkField("small.startRun", 32'(sRunning), 1);
    @(negedge clk); sStart = 0;
    repeat (15) @(posedge clk);
    #1;
    checkField("small.lastPc", 32'(sPc), 15);
    checkField("small.noFaultYet", 32'(sFault), 0);
    @(posedge clk); #1;
    checkField("small.fault", 32'(sFault), 1);
    checkField("small.faultPc", 32'(sFaultPc), 15);
    checkField("small.pcHeld", 32'(sPc), 15);
    checkField("small.running", 32'(sRunning), 0);
    checkField("small.cycle", 32'(sCycle), 16);
    checkField("small.lutAddr", 32'(sLutAddr), 0);

    // Saturation: a long stall keeps the core in RUN while the cycle counter climbs.
    applyStimulus(1, 0, 0, 0, 0, 0, 9'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 9'd0);
    @(negedge clk); start = 0; stall = 1;
    repeat (65534) @(posedge clk);
    #1 checkField("sat.beforeTop", 32'(cycleCount), 32'hFFFE);
    @(posedge clk);
    #1 checkField("sat.top", 32'(cycleCount), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    checkField("sat.hold", 32'(cycleCount), 32'hFFFF);
    checkField("sat.pc", 32'(pc), 0);
    checkField("sat.running", 32'(running), 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
